// File: rtl/draw_pkg.sv
// draw_pkg: shared types and default widths for the pixel drawing blocks.
package draw_pkg;

   // Default geometry: 14-bit word address (16K pixels), 16-bit RGB565 colour.
   localparam int DEF_ADDR_W = 14;
   localparam int DEF_DATA_W = 16;

   // Pair writer FSM: idle, then the even-address write, then the odd one.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR_A = 2'd1,
      WR_B = 2'd2
   } state_t;

endpackage

// File: rtl/pixel_pair_writer.sv
// pixel_pair_writer: takes an (even, odd) address pair plus one colour and
// issues two writes to a single-port memory, one per cycle when the memory
// is ready. A new pair can be accepted on the cycle the odd write is
// accepted, sustaining one pair every two cycles.
// Optional feature: define PIXEL_COUNT_EN to add the pix_count output, a
// running count of accepted memory writes cleared when a frame completes.
module pixel_pair_writer
   import draw_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr_a,
   input  logic [ADDR_W-1:0] in_addr_b,
   input  logic [DATA_W-1:0] in_color,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
`ifdef PIXEL_COUNT_EN
   output logic [ADDR_W:0]   pix_count,
`endif
   output logic              done
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_a_q, addr_b_q;
   logic [DATA_W-1:0]   color_q;
   logic                last_q;
   logic                xfer;
   logic                wr_accept;

   // Handshake: accept in IDLE, or in WR_B on the cycle the odd write retires.
   // Forced low during reset so nothing is taken while the block is cleared.
   always_comb begin
      in_ready = 1'b0;
      if (!reset)
         in_ready = (state_q == IDLE) || ((state_q == WR_B) && mem_ready);
   end

   assign xfer      = in_valid && in_ready;
   assign mem_we    = (state_q != IDLE);
   assign busy      = (state_q != IDLE);
   assign wr_accept = mem_we && mem_ready;
   // Addresses go straight out; the even/odd relationship is the caller's job.
   assign mem_addr  = (state_q == WR_B) ? addr_b_q : addr_a_q;
   assign mem_wdata = color_q;

   // Next-state logic for the three-state write sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (xfer) state_d = WR_A;
         WR_A: if (mem_ready) state_d = WR_B;
         WR_B: if (mem_ready) state_d = xfer ? WR_A : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, pair registers and the done pulse; reset drops any pending writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_a_q <= '0;
         addr_b_q <= '0;
         color_q  <= '0;
         last_q   <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            addr_a_q <= in_addr_a;
            addr_b_q <= in_addr_b;
            color_q  <= in_color;
            last_q   <= in_last;
         end
         done <= (state_q == WR_B) && mem_ready && last_q;
      end
   end

`ifdef PIXEL_COUNT_EN
   // Count accepted writes; restart from zero once a frame's done pulse is seen.
   always_ff @(posedge clk) begin
      if (reset)
         pix_count <= '0;
      else if (done)
         pix_count <= wr_accept ? {{ADDR_W{1'b0}}, 1'b1} : '0;
      else if (wr_accept)
         pix_count <= pix_count + {{ADDR_W{1'b0}}, 1'b1};
   end
`else
   // Handshake-complete signal has no consumer without the pixel counter.
   logic unused_wr_accept;
   assign unused_wr_accept = wr_accept;
`endif

endmodule

// File: doc/pixel_pair_writer.md
PIXEL_PAIR_WRITER -- requirements
Module: pixel_pair_writer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, meaning the width of a memory word address.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the width of a pixel colour word.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an address pair is offered on the input side.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the offered pair this cycle.
REQ-007 The block SHALL have port in_addr_a, input, ADDR_W bits: the even pixel address.
REQ-008 The block SHALL have port in_addr_b, input, ADDR_W bits: the odd pixel address.
REQ-009 The block SHALL have port in_color, input, DATA_W bits: the colour written to both addresses.
REQ-010 The block SHALL have port in_last, input, 1 bit: the pair is the final pair of the frame.
REQ-011 The block SHALL have port mem_we, output, 1 bit: a write request to the single-port memory.
REQ-012 The block SHALL have port mem_addr, output, ADDR_W bits: the write address.
REQ-013 The block SHALL have port mem_wdata, output, DATA_W bits: the write data.
REQ-014 The block SHALL have port mem_ready, input, 1 bit: the memory accepts the write this cycle.
REQ-015 The block SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: a one-cycle pulse after the last write of a frame.

Function
REQ-017 The block SHALL use exactly three FSM states: IDLE, WR_A and WR_B.
REQ-018 A transfer SHALL occur when in_valid and in_ready are both high on a rising edge; on a transfer the block SHALL register addr_a, addr_b, color and last.
REQ-019 in_ready SHALL equal (state==IDLE) OR (state==WR_B AND mem_ready), with a combinational path from mem_ready.
REQ-020 In IDLE, mem_we SHALL be 0; a transfer SHALL move the FSM to WR_A; with no transfer it SHALL stay in IDLE.
REQ-021 In WR_A, mem_we SHALL be 1, mem_addr SHALL be the registered addr_a, and mem_wdata SHALL be the registered color; mem_ready=1 SHALL move the FSM to WR_B; mem_ready=0 SHALL hold WR_A with all outputs stable.
REQ-022 In WR_B, mem_we SHALL be 1, mem_addr SHALL be the registered addr_b, and mem_wdata SHALL be the registered color; mem_ready=0 SHALL hold WR_B.
REQ-023 In WR_B with mem_ready=1 and a simultaneous transfer, the FSM SHALL go to WR_A with the new pair registered (back-to-back operation, sustaining 2 cycles per pair).
REQ-024 In WR_B with mem_ready=1 and no transfer, the FSM SHALL go to IDLE.
REQ-025 Latency SHALL be: transfer at edge T gives the addr_a write request in cycle T+1; with mem_ready=1 the addr_b write request follows in cycle T+2.
REQ-026 done SHALL be a registered 1-cycle pulse in the cycle after the WR_B write accept of a pair whose last=1; otherwise done SHALL be 0.
REQ-027 Addresses SHALL pass through unmodified, with no arithmetic and no wrap; the block SHALL perform no parity check on a/b addresses.
REQ-028 busy SHALL be 1 whenever the state is not IDLE.

Reset
REQ-029 While reset=1, state SHALL be IDLE and mem_we, done and busy SHALL be 0; registered addr, color and last SHALL be 0.
REQ-030 Reset asserted during WR_A or WR_B SHALL abandon the pending writes, with no done pulse; in_ready SHALL be 0 while reset=1.

Configuration
REQ-031 With macro PIXEL_COUNT_EN defined, the block SHALL add output pix_count [ADDR_W:0], incremented by 1 per accepted memory write, cleared by reset, and cleared on the cycle done pulses.
REQ-032 Without PIXEL_COUNT_EN, the pix_count port and its counter SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-033 Shared package draw_pkg SHALL hold the state enum type (IDLE, WR_A, WR_B) and the default ADDR_W and DATA_W localparams.
REQ-034 The block SHALL be a single module with no sub-module; the FSM and the data registers are small enough for one module.

Verification
REQ-035 Single pair a=8192, b=8193, color=16'hF800, last=0, mem_ready=1 -> writes 8192 then 8193 on T+1 and T+2, then IDLE, done=0.
REQ-036 Continuous in_valid, 4 pairs 8192..8199, mem_ready=1 -> 8 consecutive writes with no gap, in_ready high every second cycle.
REQ-037 mem_ready held 0 for 3 cycles in WR_A -> mem_addr=8192 stable for 4 cycles, in_ready=0, then normal completion.
REQ-038 Pair with last=1, a=10238, b=10239 -> done=1 exactly one cycle after the 10239 write; with PIXEL_COUNT_EN, pix_count reaches the expected total and then clears.
REQ-039 reset=1 asserted in WR_B -> next cycle IDLE, mem_we=0, done never pulses, and the next pair is accepted normally.
